// File: rtl/ws_pkg.sv
// Shared definitions for the HSV frame sequencer: FSM states, channel width
// and the breathe-mode floor level.
package ws_pkg;

    localparam int CH_W = 8;

    localparam logic [CH_W-1:0] V_MIN = 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/hsv_seq_align.sv
// Valid+tag delay line matching a downstream converter's pipeline depth.
// DEPTH=0 degenerates to a wire.
module hsv_seq_align #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign out_data = in_data;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            // NOTE: every stage is reset, not just the head, so that a reset in
            // mid-frame cannot let a stale valid bit walk out as a write strobe.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign out_data = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/hsv_frame_sequencer.sv
// Per-frame rotating-rainbow H/S/V generator with write/led_num aligned to the
// downstream converter. Define HSV_SEQ_BREATHE_EN for a per-frame V triangle wave.
module hsv_frame_sequencer
    import ws_pkg::*;
#(
    parameter int              NUM_LEDS     = 50,
    parameter int              FRAME_TICKS  = 65536,
    parameter int              HUE_ADVANCE  = 1,
    parameter logic [CH_W-1:0] SATURATION   = 8'hFF,
    parameter logic [CH_W-1:0] VALUE        = 8'd10,
    parameter int              CONV_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            ready,
    input  logic [CH_W-1:0] hue_step,
    output logic [CH_W-1:0] h,
    output logic [CH_W-1:0] s,
    output logic [CH_W-1:0] v,
    output logic            hsv_valid,
    output logic [CH_W-1:0] led_num,
    output logic            write,
    output logic            frame_done
);

    localparam int                TICK_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LOAD  = TICK_W'(FRAME_TICKS - 1);
    localparam logic [CH_W-1:0]   LAST_IDX   = CH_W'(NUM_LEDS - 1);
    localparam logic [CH_W-1:0]   ADV        = CH_W'(HUE_ADVANCE);
    localparam logic [2:0]        DRAIN_LAST = 3'(CONV_LATENCY);

    seq_state_e        state_q, state_d;
    logic [CH_W-1:0]   base_hue_q, base_hue_d;
    logic [CH_W-1:0]   hue_acc_q, hue_acc_d;
    logic [CH_W-1:0]   step_q, step_d;
    logic [CH_W-1:0]   idx_q, idx_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        drain_q, drain_d;
    logic [CH_W-1:0]   h_q, h_d;
    logic [CH_W-1:0]   s_q, s_d;
    logic [CH_W-1:0]   v_q, v_d;
    logic              hsv_valid_q, hsv_valid_d;
    logic [CH_W-1:0]   tag_q, tag_d;
    logic              frame_done_q, frame_done_d;
    logic [CH_W-1:0]   v_now;
    logic [CH_W:0]     align_out;

`ifdef HSV_SEQ_BREATHE_EN
    logic [CH_W-1:0] v_level_q, v_level_d;
    logic            v_rise_q, v_rise_d;

    assign v_now = v_level_q;
`else
    assign v_now = VALUE;
`endif

    // NOTE: every signal gets its hold value first, so no path through the case
    // leaves a _d unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        base_hue_d   = base_hue_q;
        hue_acc_d    = hue_acc_q;
        step_d       = step_q;
        idx_d        = idx_q;
        tick_d       = tick_q;
        drain_d      = drain_q;
        h_d          = h_q;
        s_d          = s_q;
        v_d          = v_q;
        tag_d        = tag_q;
        hsv_valid_d  = 1'b0;
        frame_done_d = 1'b0;
`ifdef HSV_SEQ_BREATHE_EN
        v_level_d    = v_level_q;
        v_rise_d     = v_rise_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    step_d    = hue_step;
                    idx_d     = '0;
                    hue_acc_d = base_hue_q;
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (ready) begin
                    h_d         = hue_acc_q;
                    s_d         = SATURATION;
                    v_d         = v_now;
                    hsv_valid_d = 1'b1;
                    tag_d       = idx_q;
                    hue_acc_d   = hue_acc_q + step_q;
                    idx_d       = idx_q + 8'd1;
                    if (idx_q == LAST_IDX) begin
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Stay until the last tag has left the alignment line.
                if (drain_q == DRAIN_LAST) begin
                    frame_done_d = 1'b1;
                    tick_d       = TICK_LOAD;
                    drain_d      = '0;
                    state_d      = ST_WAIT;
`ifdef HSV_SEQ_BREATHE_EN
                    if (v_rise_q) begin
                        if (v_level_q >= VALUE) begin
                            v_level_d = v_level_q - 8'd1;
                            v_rise_d  = 1'b0;
                        end else begin
                            v_level_d = v_level_q + 8'd1;
                        end
                    end else begin
                        if (v_level_q <= V_MIN) begin
                            v_level_d = v_level_q + 8'd1;
                            v_rise_d  = 1'b1;
                        end else begin
                            v_level_d = v_level_q - 8'd1;
                        end
                    end
`endif
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            ST_WAIT: begin
                if (tick_q == '0) begin
                    base_hue_d = base_hue_q + ADV;
                    step_d     = hue_step;
                    idx_d      = '0;
                    hue_acc_d  = base_hue_q + ADV;
                    state_d    = enable ? ST_EMIT : ST_IDLE;
                end else begin
                    tick_d = tick_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use <= so every flop samples the pre-edge values of
    // its peers regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            base_hue_q   <= '0;
            hue_acc_q    <= '0;
            step_q       <= '0;
            idx_q        <= '0;
            tick_q       <= '0;
            drain_q      <= '0;
            h_q          <= '0;
            s_q          <= '0;
            v_q          <= '0;
            hsv_valid_q  <= 1'b0;
            tag_q        <= '0;
            frame_done_q <= 1'b0;
`ifdef HSV_SEQ_BREATHE_EN
            v_level_q    <= V_MIN;
            v_rise_q     <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            base_hue_q   <= base_hue_d;
            hue_acc_q    <= hue_acc_d;
            step_q       <= step_d;
            idx_q        <= idx_d;
            tick_q       <= tick_d;
            drain_q      <= drain_d;
            h_q          <= h_d;
            s_q          <= s_d;
            v_q          <= v_d;
            hsv_valid_q  <= hsv_valid_d;
            tag_q        <= tag_d;
            frame_done_q <= frame_done_d;
`ifdef HSV_SEQ_BREATHE_EN
            v_level_q    <= v_level_d;
            v_rise_q     <= v_rise_d;
`endif
        end
    end

    hsv_seq_align #(
        .DEPTH (CONV_LATENCY),
        .WIDTH (CH_W + 1)
    ) u_align (
        .clk      (clk),
        .reset    (reset),
        .in_data  ({hsv_valid_q, tag_q}),
        .out_data (align_out)
    );

    assign h          = h_q;
    assign s          = s_q;
    assign v          = v_q;
    assign hsv_valid  = hsv_valid_q;
    assign frame_done = frame_done_q;
    assign write      = align_out[CH_W];
    assign led_num    = align_out[CH_W-1:0];

endmodule
